// File: rtl/spi_sram_responder.sv
// spi_sram_responder: 23LC1024-style serial SRAM model (READ/WRITE/RDMR/WRMR) over an internal byte array.
// Define SPI_SRAM_RESPONDER_QUAD_EN to add EQIO/RSTIO and SQI (quad) transfers.
module spi_sram_responder #(
    parameter int         MEM_ADDR_WIDTH = 14,
    parameter logic [7:0] INIT_BYTE      = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sram_cs_n,
    input  logic       sram_sck,
    input  logic       sram_sio0_i,
    input  logic       sram_sio1_i,
    input  logic       sram_sio2_i,
    input  logic       sram_sio3_i,
    output logic       sram_sio0_o,
    output logic       sram_sio1_o,
    output logic       sram_sio2_o,
    output logic       sram_sio3_o,
    output logic [3:0] sram_sio_oe,
    output logic       quad_mode,
    output logic       cmd_error
);
`ifdef SPI_SRAM_RESPONDER_QUAD_EN
    localparam bit QUAD_EN = 1'b1;
`else
    localparam bit QUAD_EN = 1'b0;
`endif
    localparam int DEPTH = 1 << MEM_ADDR_WIDTH;
    localparam int SW = MEM_ADDR_WIDTH > 8 ? MEM_ADDR_WIDTH : 8;
    typedef enum logic [3:0] {IDLE, CMD, ADDR, DUMMY, READ, WRITE, MODE_RD, MODE_WR, IGNORE} state_t;
    state_t state_q, state_d;
    logic sck_prev_q, quad_q, quad_d, rd_q, rd_d, err_q, err_d, we;
    logic [4:0] cnt_q, cnt_d, cnt_inc;
    logic [SW-1:0] sh_q, sh_d, sh_in;
    logic [7:0] out_q, out_d, mode_q, mode_d;
    logic [3:0] sio_q, sio_d, oe_q, oe_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0] mem_q [DEPTH] = '{default: INIT_BYTE};
    logic quad, rise, fall, done8, done24;
    assign quad    = QUAD_EN && quad_q;
    assign rise    = sram_sck & ~sck_prev_q & ~sram_cs_n;
    assign fall    = ~sram_sck & sck_prev_q & ~sram_cs_n;
    assign cnt_inc = cnt_q + (quad ? 5'd4 : 5'd1);
    assign done8   = cnt_inc == 5'd8;
    assign done24  = cnt_inc == 5'd24;
    // Only the low SW bits are kept: upper address bits simply fall off the top.
    assign sh_in   = quad ? SW'({sh_q, sram_sio3_i, sram_sio2_i, sram_sio1_i, sram_sio0_i})
                          : SW'({sh_q, sram_sio0_i});
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        out_d   = out_q;
        mode_d  = mode_q;
        sio_d   = sio_q;
        oe_d    = oe_q;
        addr_d  = addr_q;
        quad_d  = quad_q;
        rd_d    = rd_q;
        err_d   = 1'b0;
        we      = 1'b0;
        if (sram_cs_n) begin
            state_d = IDLE;
            cnt_d   = '0;
            oe_d    = '0;
            sio_d   = '0;
        end else begin
            if (state_q == IDLE) state_d = CMD;
            if (rise) begin
                sh_d  = sh_in;
                cnt_d = cnt_inc;
                case (state_q == IDLE ? CMD : state_q)
                    CMD: if (done8) begin
                        cnt_d   = '0;
                        state_d = IGNORE;
                        case (sh_in[7:0])
                            8'h03: begin state_d = ADDR; rd_d = 1'b1; end
                            8'h02: begin state_d = ADDR; rd_d = 1'b0; end
                            8'h05: begin state_d = MODE_RD; out_d = mode_q; end
                            8'h01: state_d = MODE_WR;
                            8'h38, 8'hFF: if (QUAD_EN) quad_d = sh_in[7:0] == 8'h38; else err_d = 1'b1;
                            default: err_d = 1'b1;
                        endcase
                    end
                    ADDR: if (done24) begin
                        cnt_d   = '0;
                        addr_d  = sh_in[MEM_ADDR_WIDTH-1:0];
                        state_d = !rd_q ? WRITE : quad ? DUMMY : READ;
                        if (rd_q && !quad) begin
                            out_d  = mem_q[sh_in[MEM_ADDR_WIDTH-1:0]];
                            addr_d = sh_in[MEM_ADDR_WIDTH-1:0] + 1'b1;
                        end
                    end
                    DUMMY, READ: if (done8) begin
                        cnt_d   = '0;
                        state_d = READ;
                        out_d   = mem_q[addr_q];
                        addr_d  = addr_q + 1'b1;
                    end
                    WRITE: if (done8) begin
                        cnt_d  = '0;
                        we     = 1'b1;
                        addr_d = addr_q + 1'b1;
                    end
                    MODE_RD: if (done8) begin
                        cnt_d = '0;
                        out_d = mode_q;
                    end
                    MODE_WR: if (done8) begin
                        cnt_d  = '0;
                        mode_d = sh_in[7:0];
                    end
                    default: cnt_d = cnt_q;
                endcase
            end
            if (fall && (state_q == READ || state_q == MODE_RD)) begin
                sio_d = quad ? out_q[7:4] : {2'b00, out_q[7], 1'b0};
                out_d = quad ? {out_q[3:0], 4'h0} : {out_q[6:0], 1'b0};
                oe_d  = quad ? 4'hF : 4'b0010;
            end
        end
    end
    always_ff @(posedge clk) begin
        sck_prev_q <= sram_sck;
        if (reset) begin
            state_q <= IDLE;
            quad_q  <= 1'b0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            sh_q    <= '0;
            out_q   <= '0;
            mode_q  <= 8'h40;
            sio_q   <= '0;
            oe_q    <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            quad_q  <= quad_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            out_q   <= out_d;
            mode_q  <= mode_d;
            sio_q   <= sio_d;
            oe_q    <= oe_d;
            addr_q  <= addr_d;
        end
    end
    always_ff @(posedge clk) begin
        if (we && !reset) mem_q[addr_q] <= sh_in[7:0];
    end
    assign sram_sio0_o = sio_q[0];
    assign sram_sio1_o = sio_q[1];
    assign sram_sio2_o = sio_q[2];
    assign sram_sio3_o = sio_q[3];
    assign sram_sio_oe = oe_q;
    assign quad_mode   = quad;
    assign cmd_error   = err_q;
endmodule
